// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button debounce/repeat block.
// All tick-based values are in 10 ms tick_input periods.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int BTN_NUM          = 4;
    localparam int BTN_STABLE_TICKS = 3;
    localparam int BTN_REPEAT_DELAY = 30;
    localparam int BTN_REPEAT_RATE  = 8;

    function automatic int btn_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: tick-sampled debounce counter plus IDLE/HELD/REPEAT hold-to-repeat FSM.
// level/press are registered and only move on tick cycles; press self-clears every cycle.
module btn_channel
    import btn_pkg::*;
#(
    parameter int STABLE_TICKS = BTN_STABLE_TICKS,
    parameter int REPEAT_DELAY = BTN_REPEAT_DELAY,
    parameter int REPEAT_RATE  = BTN_REPEAT_RATE,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic tick_input,
    input  logic pressed_sync,
    output logic level,
    output logic press
);

    localparam int SW   = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam int RMAX = btn_max(REPEAT_DELAY, REPEAT_RATE);
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX + 1) : 1;

    localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_TICKS - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
    localparam logic [RW-1:0] DELAY_SAT  = RW'(REPEAT_DELAY);

    btn_state_t    state_q, state_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          level_d, press_d;
    logic          accept;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            stab_q  <= '0;
            rep_q   <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            rep_q   <= rep_d;
            level   <= level_d;
            press   <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        rep_d   = rep_q;
        level_d = level;
        press_d = 1'b0;
        accept  = 1'b0;

        if (tick_input) begin
            // Debounce: streak of samples disagreeing with the accepted level
            if (pressed_sync == level) begin
                stab_d = '0;
            end else if (stab_q == STAB_LAST) begin
                accept = 1'b1;
                stab_d = '0;
            end else begin
                stab_d = stab_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        level_d = 1'b1;
                        press_d = 1'b1;
                        rep_d   = '0;
                        state_d = HELD;
                    end
                end
                HELD: begin
                    // A release on the threshold tick wins: checked before the repeat
                    if (accept) begin
                        level_d = 1'b0;
                        rep_d   = '0;
                        state_d = IDLE;
                    end else if (REPEAT_EN) begin
                        if (rep_q == DELAY_LAST) begin
                            press_d = 1'b1;
                            rep_d   = '0;
                            state_d = REPEAT;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end else if (rep_q != DELAY_SAT) begin
                        // Non-repeating buttons just saturate so the counter never wraps
                        rep_d = rep_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (accept) begin
                        level_d = 1'b0;
                        rep_d   = '0;
                        state_d = IDLE;
                    end else if (rep_q == RATE_LAST) begin
                        press_d = 1'b1;
                        rep_d   = '0;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
                default: begin
                    level_d = 1'b0;
                    rep_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_debounce_repeat.sv
// Raw KEY pins -> 2-flop synchronizer -> per-button debounce and hold-to-repeat channels.
// Produces debounced level plus single-cycle press strobes for the game control FSM.
module btn_debounce_repeat
    import btn_pkg::*;
#(
    parameter int                 NUM_BTN      = BTN_NUM,
    parameter int                 STABLE_TICKS = BTN_STABLE_TICKS,
    parameter int                 REPEAT_DELAY = BTN_REPEAT_DELAY,
    parameter int                 REPEAT_RATE  = BTN_REPEAT_RATE,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK  = NUM_BTN'(4'b0111)
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               tick_input,
    input  logic [NUM_BTN-1:0] key_n,
    output logic [NUM_BTN-1:0] level,
    output logic [NUM_BTN-1:0] press
);

    if (STABLE_TICKS < 1) begin : g_bad_stable
        $error("STABLE_TICKS must be >= 1");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_RATE < 1) begin : g_bad_rate
        $error("REPEAT_RATE must be >= 1");
    end

    logic [1:0][NUM_BTN-1:0] sync_pipe;
    logic [NUM_BTN-1:0]      pressed_sync;

    // Reset to all-released so a key held through reset must re-qualify
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync_pipe <= '1;
        end else begin
            sync_pipe <= {sync_pipe[0], key_n};
        end
    end

    assign pressed_sync = ~sync_pipe[1];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .STABLE_TICKS(STABLE_TICKS),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE),
            .REPEAT_EN   (REPEAT_MASK[i])
        ) u_ch (
            .CLOCK_50    (CLOCK_50),
            .resetn      (resetn),
            .tick_input  (tick_input),
            .pressed_sync(pressed_sync[i]),
            .level       (level[i]),
            .press       (press[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Randomized + directed bench for btn_debounce_repeat against a tick-schedule reference model.
// Ticks are issued every 4 cycles; keys change right after a tick so the synchronizer settles.
module tb_btn_debounce_repeat;
    import btn_pkg::*;

    localparam int         NB   = 4;
    localparam int         ST   = BTN_STABLE_TICKS;
    localparam int         RD   = BTN_REPEAT_DELAY;
    localparam int         RR   = BTN_REPEAT_RATE;
    localparam logic [3:0] MASK = 4'b0111;

    logic          CLOCK_50   = 1'b0;
    logic          resetn     = 1'b0;
    logic          tick_input = 1'b0;
    logic [NB-1:0] key_n      = '1;
    logic [NB-1:0] level;
    logic [NB-1:0] press;

    int checks  = 0;
    int errors  = 0;
    int tick_no = 0;

    bit m_level [NB];
    int m_run   [NB];
    int m_acc   [NB];
    int n_press [NB];

    btn_debounce_repeat u_dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .tick_input(tick_input),
        .key_n     (key_n),
        .level     (level),
        .press     (press)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @tick %0d: got %0h required %0h", tag, tick_no, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] exp_level();
        logic [NB-1:0] v;
        for (int b = 0; b < NB; b++) v[b] = m_level[b];
        return v;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_level[b] = 1'b0;
            m_run[b]   = 0;
            m_acc[b]   = 0;
        end
    endtask

    // Pulse on acceptance, then at acc+RD and every RR after while still held
    task automatic model_tick(input logic [NB-1:0] kn, output logic [NB-1:0] ep);
        ep = '0;
        for (int b = 0; b < NB; b++) begin
            bit s;
            bit just_pressed;
            int d;
            s = ~kn[b];
            just_pressed = 1'b0;
            if (s != m_level[b]) begin
                m_run[b]++;
                if (m_run[b] == ST) begin
                    m_run[b]   = 0;
                    m_level[b] = s;
                    if (s) begin
                        m_acc[b]     = tick_no;
                        ep[b]        = 1'b1;
                        just_pressed = 1'b1;
                    end
                end
            end else begin
                m_run[b] = 0;
            end
            if (m_level[b] && !just_pressed && MASK[b]) begin
                d = tick_no - m_acc[b];
                if (d == RD || (d > RD && (d - RD) % RR == 0)) ep[b] = 1'b1;
            end
        end
    endtask

    task automatic step(input logic [NB-1:0] kn);
        logic [NB-1:0] ep;
        key_n = kn;
        repeat (3) begin
            @(posedge CLOCK_50); #1;
            chk("quiet_press", press, 0);
            chk("quiet_level", level, exp_level());
        end
        tick_input = 1'b1;
        @(posedge CLOCK_50); #1;
        tick_input = 1'b0;
        tick_no++;
        model_tick(kn, ep);
        chk("tick_press", press, ep);
        chk("tick_level", level, exp_level());
        for (int b = 0; b < NB; b++) if (press[b]) n_press[b]++;
    endtask

    task automatic steps(input logic [NB-1:0] kn, input int n);
        for (int i = 0; i < n; i++) step(kn);
    endtask

    task automatic clr_counts();
        for (int b = 0; b < NB; b++) n_press[b] = 0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        resetn = 1'b0;
        #1;
        chk("rst_level", level, 0);
        chk("rst_press", press, 0);
        model_reset();
        @(posedge CLOCK_50); #1;
        resetn = 1'b1;
    endtask

    initial begin
        int            remain [NB];
        logic [NB-1:0] base;
        model_reset();
        clr_counts();
        #2;
        chk("por_level", level, 0);
        chk("por_press", press, 0);
        repeat (2) @(posedge CLOCK_50);
        #1 resetn = 1'b1;

        // Idle
        clr_counts();
        steps(4'hF, 100);
        chk("idle_pulses", n_press[0] + n_press[1] + n_press[2] + n_press[3], 0);

        // Bounce on button 0, then settle low
        clr_counts();
        for (int i = 0; i < 10; i++) step((i % 2 == 0) ? 4'hE : 4'hF);
        steps(4'hE, 6);
        chk("bounce_pulses", n_press[0], 1);
        chk("bounce_level", level[0], 1);
        steps(4'hF, 5);

        // Hold button 1 through T+60, then release
        clr_counts();
        steps(4'hD, 62);
        steps(4'hF, 3);
        chk("repeat_pulses", n_press[1], 5);
        chk("repeat_rel_level", level[1], 0);
        steps(4'hF, 2);

        // Non-repeating button 3
        clr_counts();
        steps(4'h7, 62);
        chk("norep_level", level[3], 1);
        chk("norep_pulses", n_press[3], 1);
        steps(4'hF, 4);

        // Release qualifies on the same tick as the first repeat
        clr_counts();
        steps(4'hE, 30);
        steps(4'hF, 3);
        chk("relwin_pulses", n_press[0], 1);
        chk("relwin_level", level[0], 0);
        steps(4'hF, 2);

        // Reset while button 1 is repeating, key still held afterwards
        clr_counts();
        steps(4'hD, 45);
        do_reset();
        clr_counts();
        steps(4'hD, 41);
        chk("post_rst_pulses", n_press[1], 3);
        chk("post_rst_level", level[1], 1);
        steps(4'hF, 4);

        // Random holds with occasional single-tick glitches
        base = '1;
        for (int b = 0; b < NB; b++) remain[b] = $urandom_range(1, 45);
        for (int t = 0; t < 300; t++) begin
            automatic logic [NB-1:0] kn;
            automatic int            gb;
            for (int b = 0; b < NB; b++) begin
                if (remain[b] == 0) begin
                    base[b]   = ~base[b];
                    remain[b] = $urandom_range(1, 45);
                end else begin
                    remain[b]--;
                end
            end
            kn = base;
            if ($urandom_range(0, 15) == 0) begin
                gb = $urandom_range(0, NB - 1);
                kn[gb] = ~kn[gb];
            end
            step(kn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce_repeat.md
# btn_debounce_repeat

Debounces the board push-buttons and turns each button into clean game-move strobes, with hold-to-repeat (DAS). It sits between the raw `KEY` pins and the game control FSM. It consumes the 10 ms `tick_input` strobe from the tick generator as its only time base. Outputs are single-cycle `press` pulses in the `CLOCK_50` domain, plus a debounced `level`.

## Interface
- `NUM_BTN`, 4, number of buttons handled.
- `STABLE_TICKS`, 3, consecutive tick samples needed to accept a level change. Must be ≥1.
- `REPEAT_DELAY`, 30, ticks from the press pulse to the first repeat pulse (300 ms). Must be ≥1.
- `REPEAT_RATE`, 8, ticks between subsequent repeat pulses (80 ms). Must be ≥1.
- `REPEAT_MASK`, 4'b0111, per-button auto-repeat enable. The rotate button does not repeat.
- `CLOCK_50` in 1: system clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `tick_input` in 1: one-cycle sample strobe. Any spacing ≥1 cycle is legal, including every cycle.
- `key_n` in NUM_BTN: raw buttons, active-low, asynchronous to `CLOCK_50`.
- `level` out NUM_BTN: debounced pressed state, active-high.
- `press` out NUM_BTN: one-cycle pulse on each accepted press and on each repeat.

## Operation
- **Synchronizer:** `key_n` passes through a 2-flop synchronizer, reset to 1 (released), then is inverted to give `pressed_sync`.
- **Sampling:** only cycles with `tick_input=1` sample. Non-tick cycles change nothing except clearing `press`.
- **Debounce (per button):**
  - `stab_cnt` counts consecutive tick samples that differ from `level`.
  - A sample equal to `level` clears `stab_cnt`.
  - When a differing sample brings the streak to `STABLE_TICKS`, `level` toggles and `stab_cnt` clears.
- **Per-button FSM, IDLE / HELD / REPEAT:**
  - IDLE: `level=0`. An accepted press sets `level`, pulses `press`, clears `rep_cnt`, and enters HELD.
  - HELD: each tick increments `rep_cnt`. If `REPEAT_MASK[i]=0`, the FSM stays in HELD and never pulses again. Otherwise, when `rep_cnt` reaches `REPEAT_DELAY`, it pulses `press`, clears `rep_cnt`, and enters REPEAT.
  - REPEAT: each tick increments `rep_cnt`. On reaching `REPEAT_RATE`, it pulses `press` and clears `rep_cnt`.
  - From HELD or REPEAT, an accepted release clears `level` and returns to IDLE with no pulse.
- **Coincident release and repeat threshold:** the release wins. No pulse is produced.
- **Button independence:** buttons are fully independent. Simultaneous pulses on several bits are legal. No left/right arbitration is done here; the consumer handles it.
- **Counter width:** `rep_cnt` width is `$clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)`. The counter never wraps, because it is cleared at its threshold.
- **Reset mid-operation:** all state is cleared. A key held through reset is treated as a new press and must re-qualify over `STABLE_TICKS` ticks. It then pulses once and restarts the full `REPEAT_DELAY`.

## Timing
- **Reset values:** `level=0`, `press=0`, synchronizer=1, `stab_cnt=0`, `rep_cnt=0`, state IDLE.
- **Input latency:** 2 cycles from a `key_n` edge to `pressed_sync`.
- **Pulse timing:** `level` and `press` are registered. They update at the edge that ends the qualifying tick cycle, so `press` is high for exactly the one cycle after that tick.
- **Press/level alignment:** `press` and the rising edge of `level` appear in the same cycle.
- **Repeat schedule:** with the press accepted at tick T, repeats occur at ticks T+REPEAT_DELAY and then T+REPEAT_DELAY+k·REPEAT_RATE for k=1,2,…
- **Back-to-back ticks:** `press` is high for one cycle per qualifying tick. Consecutive-cycle pulses are possible only with REPEAT_RATE=1 and `tick_input` tied high.

## Structure
- Package `btn_pkg`:
  - `btn_state_t` enum (IDLE, HELD, REPEAT).
  - Default constants `BTN_STABLE_TICKS`, `BTN_REPEAT_DELAY`, `BTN_REPEAT_RATE`.
- Sub-module `btn_channel`:
  - Contains one button's debounce counter, FSM and `rep_cnt`.
  - Instantiated `NUM_BTN` times in a generate loop, with `REPEAT_MASK[i]` passed as a 1-bit parameter.
- The synchronizer lives in the top level.

## Test plan
All scenarios use default parameters and `tick_input` pulsed every 4 cycles.
1. **Idle:** `key_n`=4'hF for 100 ticks → `press`=0 and `level`=0 throughout.
2. **Bounce:** `key_n[0]` toggles on each tick for 10 ticks, then held 0 → exactly one `press[0]` pulse, in the cycle after the 3rd consecutive low sample.
3. **Repeat:** `key_n[1]` held low for 60 ticks after acceptance at T → pulses at T, T+30, T+38, T+46, T+54 (5 total), then release → `level[1]`=0 3 ticks later with no pulse.
4. **No-repeat button:** `key_n[3]` held 60 ticks → exactly one pulse, and `level[3]` stays 1.
5. **Release beats repeat:** button 0 accepted at T; release timed so its qualifying tick is T+30 → no pulse at T+30, and `level[0]` falls.
6. **Reset mid-REPEAT:** assert `resetn`=0 mid-cycle with the key held → `level`/`press` go 0 immediately. After deassert with the key still held → press 3 ticks later, first repeat 30 ticks after that.
